bf_lut_cfg_ctrl: RTL and testbench

- Configuration sequencer for the bloom filter hash LUT and enable CSR.
- Accepts a host command, disables the filter through the CSR slave, waits for the datapath to drain, then optionally sweeps the hash LUT to zero and/or streams new LUT entries, and re-enables the filter.
- Sits between the host/config fabric and the bloom filter's amm_slave_csr/amm_slave_lut ports. It is the only master of the LUT port.

---
 rtl/bf_lut_cfg_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_bf_lut_cfg_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_lut_cfg_ctrl.sv
// Configuration sequencer: disables the bloom filter, waits for the datapath to drain,
// optionally cleans/loads the hash LUT, then re-enables. Optional macro: BF_LUT_CFG_LOAD_CNT_EN.
module bf_lut_cfg_ctrl #(
    parameter int unsigned AMM_LUT_ADDR_W = 12,
    parameter int unsigned AMM_LUT_DATA_W = 32,
    parameter int unsigned AMM_CSR_ADDR_W = 4,
    parameter int unsigned AMM_CSR_DATA_W = 32,
    parameter int unsigned EN_REG_ADDR    = 0,
    parameter int unsigned IDLE_TIMEOUT   = 1024
) (
    input  logic                      main_clk_i,
    input  logic                      main_srst_n_i,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic [1:0]                cmd_op_i,
    input  logic                      entry_valid_i,
    output logic                      entry_ready_o,
    input  logic [AMM_LUT_ADDR_W-1:0] entry_addr_i,
    input  logic [AMM_LUT_DATA_W-1:0] entry_data_i,
    input  logic                      entry_last_i,
    input  logic                      dp_busy_i,
    output logic [AMM_CSR_ADDR_W-1:0] csr_address_o,
    output logic                      csr_write_o,
    output logic [AMM_CSR_DATA_W-1:0] csr_writedata_o,
    output logic [AMM_LUT_ADDR_W-1:0] lut_address_o,
    output logic                      lut_write_o,
    output logic [AMM_LUT_DATA_W-1:0] lut_writedata_o,
`ifdef BF_LUT_CFG_LOAD_CNT_EN
    output logic [AMM_LUT_ADDR_W:0]   load_cnt_o,
`endif
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      timeout_err_o
);

    localparam int unsigned TO_W = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_DISABLE   = 3'd1;
    localparam logic [2:0] S_WAIT_IDLE = 3'd2;
    localparam logic [2:0] S_CLEAN     = 3'd3;
    localparam logic [2:0] S_LOAD      = 3'd4;
    localparam logic [2:0] S_ENABLE    = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;

    logic [2:0]                state_q, state_d;
    logic [1:0]                op_q, op_d;
    logic [TO_W-1:0]           to_cnt_q, to_cnt_d, to_cnt_inc;
    logic                      idle_seen_q, idle_seen_d;
    logic                      last_seen_q, last_seen_d;

    logic                      cmd_ready_q, cmd_ready_d;
    logic                      entry_ready_q, entry_ready_d;
    logic [AMM_CSR_ADDR_W-1:0] csr_address_q, csr_address_d;
    logic                      csr_write_q, csr_write_d;
    logic [AMM_CSR_DATA_W-1:0] csr_writedata_q, csr_writedata_d;
    logic [AMM_LUT_ADDR_W-1:0] lut_address_q, lut_address_d;
    logic                      lut_write_q, lut_write_d;
    logic [AMM_LUT_DATA_W-1:0] lut_writedata_q, lut_writedata_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      timeout_err_q, timeout_err_d;

    logic                      cmd_fire;
    logic                      entry_fire;

    assign cmd_fire   = cmd_valid_i && cmd_ready_q;
    assign entry_fire = entry_valid_i && entry_ready_q;
    assign to_cnt_inc = to_cnt_q + TO_W'(1);

    // Next state, then registered outputs decoded from the state being entered
    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        to_cnt_d        = to_cnt_q;
        idle_seen_d     = idle_seen_q;
        last_seen_d     = last_seen_q;
        timeout_err_d   = timeout_err_q;
        cmd_ready_d     = 1'b0;
        entry_ready_d   = 1'b0;
        csr_address_d   = '0;
        csr_write_d     = 1'b0;
        csr_writedata_d = '0;
        lut_address_d   = '0;
        lut_write_d     = 1'b0;
        lut_writedata_d = '0;
        busy_d          = 1'b0;
        done_d          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    op_d          = cmd_op_i;
                    timeout_err_d = 1'b0;
                    last_seen_d   = 1'b0;
                    state_d       = S_DISABLE;
                end
            end
            S_DISABLE: begin
                to_cnt_d    = '0;
                idle_seen_d = 1'b0;
                state_d     = S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                to_cnt_d    = to_cnt_inc;
                idle_seen_d = !dp_busy_i;
                // Two quiet cycles take priority over a coincident timeout
                if (!dp_busy_i && idle_seen_q) begin
                    case (op_q)
                        2'd0:    state_d = S_ENABLE;
                        2'd2:    state_d = S_LOAD;
                        default: state_d = S_CLEAN;
                    endcase
                end else if (to_cnt_inc == TO_W'(IDLE_TIMEOUT)) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            S_CLEAN: begin
                if (lut_address_q == {AMM_LUT_ADDR_W{1'b1}}) begin
                    state_d = op_q[1] ? S_LOAD : S_ENABLE;
                end
            end
            S_LOAD: begin
                if (last_seen_q) begin
                    state_d = S_ENABLE;
                end else if (entry_fire && entry_last_i) begin
                    last_seen_d = 1'b1;
                end
            end
            S_ENABLE: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);

        if (state_d == S_DISABLE || state_d == S_ENABLE) begin
            csr_write_d     = 1'b1;
            csr_address_d   = AMM_CSR_ADDR_W'(EN_REG_ADDR);
            csr_writedata_d = (state_d == S_ENABLE) ? AMM_CSR_DATA_W'(1) : '0;
        end

        if (state_d == S_CLEAN) begin
            lut_write_d   = 1'b1;
            lut_address_d = (state_q == S_CLEAN) ? lut_address_q + AMM_LUT_ADDR_W'(1) : '0;
        end

        if (state_d == S_LOAD) begin
            entry_ready_d = !last_seen_d;
            if (entry_fire) begin
                lut_write_d     = 1'b1;
                lut_address_d   = entry_addr_i;
                lut_writedata_d = entry_data_i;
            end
        end
    end

    always_ff @(posedge main_clk_i) begin
        if (!main_srst_n_i) begin
            state_q         <= S_IDLE;
            op_q            <= '0;
            to_cnt_q        <= '0;
            idle_seen_q     <= 1'b0;
            last_seen_q     <= 1'b0;
            cmd_ready_q     <= 1'b1;
            entry_ready_q   <= 1'b0;
            csr_address_q   <= '0;
            csr_write_q     <= 1'b0;
            csr_writedata_q <= '0;
            lut_address_q   <= '0;
            lut_write_q     <= 1'b0;
            lut_writedata_q <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            timeout_err_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            op_q            <= op_d;
            to_cnt_q        <= to_cnt_d;
            idle_seen_q     <= idle_seen_d;
            last_seen_q     <= last_seen_d;
            cmd_ready_q     <= cmd_ready_d;
            entry_ready_q   <= entry_ready_d;
            csr_address_q   <= csr_address_d;
            csr_write_q     <= csr_write_d;
            csr_writedata_q <= csr_writedata_d;
            lut_address_q   <= lut_address_d;
            lut_write_q     <= lut_write_d;
            lut_writedata_q <= lut_writedata_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            timeout_err_q   <= timeout_err_d;
        end
    end

`ifdef BF_LUT_CFG_LOAD_CNT_EN
    logic [AMM_LUT_ADDR_W:0] load_cnt_q;

    // Saturating count of LUT writes issued by the load phase of the current command
    always_ff @(posedge main_clk_i) begin
        if (!main_srst_n_i) begin
            load_cnt_q <= '0;
        end else if (cmd_fire) begin
            load_cnt_q <= '0;
        end else if (entry_fire && (load_cnt_q != {(AMM_LUT_ADDR_W+1){1'b1}})) begin
            load_cnt_q <= load_cnt_q + (AMM_LUT_ADDR_W+1)'(1);
        end
    end

    assign load_cnt_o = load_cnt_q;
`endif

    assign cmd_ready_o     = cmd_ready_q;
    assign entry_ready_o   = entry_ready_q;
    assign csr_address_o   = csr_address_q;
    assign csr_write_o     = csr_write_q;
    assign csr_writedata_o = csr_writedata_q;
    assign lut_address_o   = lut_address_q;
    assign lut_write_o     = lut_write_q;
    assign lut_writedata_o = lut_writedata_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign timeout_err_o   = timeout_err_q;

endmodule

// File: tb/tb_bf_lut_cfg_ctrl.sv
// Scoreboard bench for bf_lut_cfg_ctrl: expected CSR/LUT writes and done pulses are queued
// by the stimulus and popped by an independent output monitor.
module tb_bf_lut_cfg_ctrl;

    localparam int unsigned LW  = 4;
    localparam int unsigned LDW = 32;
    localparam int unsigned CW  = 4;
    localparam int unsigned CDW = 32;
    localparam int unsigned TO  = 12;

    logic           clk = 1'b0;
    logic           srst_n = 1'b0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready_o;
    logic [1:0]     cmd_op = 2'd0;
    logic           entry_valid = 1'b0;
    logic           entry_ready_o;
    logic [LW-1:0]  entry_addr = '0;
    logic [LDW-1:0] entry_data = '0;
    logic           entry_last = 1'b0;
    logic           dp_busy = 1'b0;
    logic [CW-1:0]  csr_address_o;
    logic           csr_write_o;
    logic [CDW-1:0] csr_writedata_o;
    logic [LW-1:0]  lut_address_o;
    logic           lut_write_o;
    logic [LDW-1:0] lut_writedata_o;
    logic           busy_o, done_o, timeout_err_o;
`ifdef BF_LUT_CFG_LOAD_CNT_EN
    logic [LW:0]    load_cnt_o;
`endif

    bf_lut_cfg_ctrl #(
        .AMM_LUT_ADDR_W(LW), .AMM_LUT_DATA_W(LDW), .AMM_CSR_ADDR_W(CW),
        .AMM_CSR_DATA_W(CDW), .EN_REG_ADDR(0), .IDLE_TIMEOUT(TO)
    ) dut (
        .main_clk_i(clk), .main_srst_n_i(srst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op),
        .entry_valid_i(entry_valid), .entry_ready_o(entry_ready_o),
        .entry_addr_i(entry_addr), .entry_data_i(entry_data), .entry_last_i(entry_last),
        .dp_busy_i(dp_busy),
        .csr_address_o(csr_address_o), .csr_write_o(csr_write_o), .csr_writedata_o(csr_writedata_o),
        .lut_address_o(lut_address_o), .lut_write_o(lut_write_o), .lut_writedata_o(lut_writedata_o),
`ifdef BF_LUT_CFG_LOAD_CNT_EN
        .load_cnt_o(load_cnt_o),
`endif
        .busy_o(busy_o), .done_o(done_o), .timeout_err_o(timeout_err_o)
    );

    // kind: 0 = CSR write, 1 = LUT write, 2 = done pulse; cyc < 0 means timing unchecked
    typedef struct {
        int          kind;
        int          addr;
        logic [31:0] data;
        int          cyc;
    } ev_t;

    ev_t         exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          ent_addr[8];
    logic [31:0] ent_data[8];
    int          ent_n = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int kind, input int addr, input logic [31:0] data, input int c);
        ev_t e;
        e.kind = kind; e.addr = addr; e.data = data; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic see(input int kind, input int addr, input logic [31:0] data);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d addr 0x%0h data 0x%0h, required none (cycle %0d)",
                     kind, addr, data, cyc);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind_addr_data", 128'({kind, addr, data}), 128'({e.kind, e.addr, e.data}));
            if (e.cyc >= 0) chk("event_cycle", 128'(cyc), 128'(e.cyc));
        end
    endtask

    // Output monitor
    always @(negedge clk) begin
        if (csr_write_o || lut_write_o)
            chk("csr_lut_exclusive", 128'(csr_write_o & lut_write_o), 128'(0));
        if (csr_write_o) see(0, int'(csr_address_o), csr_writedata_o);
        if (lut_write_o) see(1, int'(lut_address_o), lut_writedata_o);
        if (done_o)      see(2, 0, 32'd0);
    end

    function automatic logic [78:0] outs();
        return {cmd_ready_o, entry_ready_o, csr_write_o, csr_address_o, csr_writedata_o,
                lut_write_o, lut_address_o, lut_writedata_o, busy_o, done_o, timeout_err_o};
    endfunction

    task automatic issue(input logic [1:0] op, output int k);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        chk("cmd_ready_before_accept", 128'(cmd_ready_o), 128'(1));
        @(posedge clk);
        #1;
        k = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic send_entries();
        for (int i = 0; i < ent_n; i++) begin
            bit acc = 1'b0;
            int guard = 0;
            while (!acc && guard < 500) begin
                logic rdy;
                @(negedge clk);
                entry_valid = 1'($urandom_range(0, 1));
                entry_addr  = LW'(ent_addr[i]);
                entry_data  = ent_data[i];
                entry_last  = (i == ent_n - 1);
                rdy = entry_ready_o;
                @(posedge clk);
                if (entry_valid && rdy) acc = 1'b1;
                guard++;
            end
            if (!acc) chk("entry_accept_timeout", 128'(0), 128'(1));
        end
        @(negedge clk);
        entry_valid = 1'b0;
        entry_last  = 1'b0;
    endtask

    task automatic push_load_tail(input logic [1:0] op, input int clean_start);
        if (op[0]) for (int i = 0; i < 16; i++)
            push(1, i, 32'd0, (clean_start >= 0) ? clean_start + i : -1);
        if (op[1]) for (int i = 0; i < ent_n; i++) push(1, ent_addr[i], ent_data[i], -1);
        push(0, 0, 32'd1, -1);
        push(2, 0, 32'd0, -1);
    endtask

    task automatic wait_drain(input string name);
        int g = 0;
        while ((exp_q.size() != 0 || !cmd_ready_o) && g < 400) begin
            @(negedge clk);
            g++;
        end
        chk(name, 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        int k, c, nb;
        logic [1:0] op;
        logic [78:0] rst_exp;
        rst_exp = {1'b1, 78'd0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 128'(outs()), 128'(rst_exp));
`ifdef BF_LUT_CFG_LOAD_CNT_EN
        chk("reset_load_cnt", 128'(load_cnt_o), 128'(0));
`endif
        srst_n = 1'b1;

        // Op 0: re-enable only, exact latency
        issue(2'd0, k);
        push(0, 0, 32'd0, k);
        push(0, 0, 32'd1, k + 3);
        push(2, 0, 32'd0, k + 4);
        while (cyc < k + 4) @(negedge clk);
        chk("op0_ready_low_in_done", 128'(cmd_ready_o), 128'(0));
        @(negedge clk);
        chk("op0_ready_after_done", 128'({cmd_ready_o, busy_o}), 128'(2'b10));
        wait_drain("op0_drain");

        // Op 1: clean sweep of 16 words, back-to-back
        issue(2'd1, k);
        push(0, 0, 32'd0, k);
        push_load_tail(2'd1, k + 3);
        wait_drain("op1_drain");

        // Op 2: three entries with random valid gaps
        ent_n = 3;
        ent_addr[0] = 5; ent_data[0] = 32'hA;
        ent_addr[1] = 9; ent_data[1] = 32'hB;
        ent_addr[2] = 2; ent_data[2] = 32'hC;
        issue(2'd2, k);
        push(0, 0, 32'd0, k);
        push_load_tail(2'd2, -1);
        send_entries();
        wait_drain("op2_drain");
`ifdef BF_LUT_CFG_LOAD_CNT_EN
        chk("op2_load_cnt", 128'(load_cnt_o), 128'(3));
`endif

        // Op 3: busy window sized so the second quiet cycle coincides with the timeout limit
        ent_n = 2;
        ent_addr[0] = 14; ent_data[0] = 32'h1234_5678;
        ent_addr[1] = 3;  ent_data[1] = 32'hDEAD_BEEF;
        dp_busy = 1'b1;
        issue(2'd3, k);
        push(0, 0, 32'd0, k);
        fork
            begin
                while (cyc < k + 11) @(negedge clk);
                dp_busy = 1'b0;
                c = cyc;
                push_load_tail(2'd3, c + 2);
            end
            send_entries();
        join
        wait_drain("op3_drain");
        chk("op3_no_timeout", 128'(timeout_err_o), 128'(0));

        // Datapath never drains: timeout, filter left disabled
        dp_busy = 1'b1;
        issue(2'd0, k);
        push(0, 0, 32'd0, k);
        while (cyc < k + TO) @(negedge clk);
        chk("timeout_not_yet", 128'({timeout_err_o, busy_o}), 128'(2'b01));
        @(negedge clk);
        chk("timeout_flag_idle", 128'({timeout_err_o, cmd_ready_o, busy_o, done_o}), 128'(4'b1100));
        repeat (4) @(negedge clk);
        chk("timeout_sticky", 128'(timeout_err_o), 128'(1));
        dp_busy = 1'b0;
        issue(2'd0, k);
        push(0, 0, 32'd0, k);
        push(0, 0, 32'd1, k + 3);
        push(2, 0, 32'd0, k + 4);
        @(negedge clk);
        chk("timeout_cleared_on_accept", 128'(timeout_err_o), 128'(0));
        wait_drain("after_timeout_drain");

        // Reset in the middle of a clean sweep
        issue(2'd1, k);
        push(0, 0, 32'd0, k);
        push_load_tail(2'd1, k + 3);
        c = 0;
        while (c < 100) begin
            @(negedge clk);
            #1;
            if (lut_write_o && lut_address_o == LW'(7)) break;
            c++;
        end
        chk("reached_clean_addr7", 128'(c < 100), 128'(1));
        srst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        srst_n = 1'b1;
        @(negedge clk);
        chk("midclean_reset_outputs", 128'(outs()), 128'(rst_exp));
        repeat (6) @(negedge clk);
        chk("midclean_reset_quiet", 128'({busy_o, cmd_ready_o}), 128'(2'b01));

        // Randomized commands against the sequence model
        for (int it = 0; it < 6; it++) begin
            op    = 2'($urandom_range(0, 3));
            nb    = int'($urandom_range(0, 4));
            ent_n = int'($urandom_range(1, 4));
            for (int i = 0; i < ent_n; i++) begin
                ent_addr[i] = int'($urandom_range(0, 15));
                ent_data[i] = $urandom;
            end
            dp_busy = (nb > 0);
            issue(op, k);
            push(0, 0, 32'd0, k);
            push_load_tail(op, -1);
            fork
                begin
                    repeat (nb) @(negedge clk);
                    dp_busy = 1'b0;
                end
                begin
                    if (op[1]) send_entries();
                end
            join
            wait_drain("random_drain");
`ifdef BF_LUT_CFG_LOAD_CNT_EN
            chk("random_load_cnt", 128'(load_cnt_o), 128'(op[1] ? ent_n : 0));
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion, required end of test");
        $fatal(1, "watchdog");
    end

endmodule
